// File: rtl/simple_dual_port_ram_pipe.sv
// Simple dual-port RAM with byte-lane writes, 1- or 2-cycle pipelined reads,
// selectable read-during-write behaviour and a self-clearing start-up sequence.
module simple_dual_port_ram_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int BYTE_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wen,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
    input  logic                             ren,
    input  logic [ADDR_WIDTH-1:0]            raddr,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             rvalid,
    output logic                             init_done
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    init_done_q, init_done_d;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [NB-1:0]           mem_wmask;
    logic                    user_we;
    logic                    rd_accept;

    logic [DATA_WIDTH-1:0]   rd_raw;
    logic [DATA_WIDTH-1:0]   merged_word;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic                    rd1_valid_q, rd1_valid_d;
    logic [DATA_WIDTH-1:0]   rd1_data_q, rd1_data_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // The clear sequence and user writes share the single write port.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        mem_we      = 1'b0;
        mem_waddr   = cnt_q;
        mem_wdata   = '0;
        mem_wmask   = '1;
        user_we     = 1'b0;
        rd_accept   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (&cnt_q) begin
                    state_d     = ST_READY;
                    init_done_d = 1'b1;
                end
            end
            ST_READY: begin
                user_we   = wen;
                mem_we    = wen;
                mem_waddr = waddr;
                mem_wdata = wdata;
                mem_wmask = wbe;
                rd_accept = ren;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    // Array has no reset term; its contents come only from the clear sequence.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (mem_wmask[i]) begin
                    mem[mem_waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign rd_raw = mem[raddr];

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_merge
            assign merged_word[gi*BYTE_WIDTH +: BYTE_WIDTH] =
                wbe[gi] ? wdata[gi*BYTE_WIDTH +: BYTE_WIDTH] : rd_raw[gi*BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    // Forward the in-flight write only in new-data mode on an address collision.
    always_comb begin
        rd_word = rd_raw;
        if ((RDW_MODE == 1) && user_we && (waddr == raddr)) begin
            rd_word = merged_word;
        end
    end

    always_comb begin
        rd1_valid_d = rd_accept;
        rd1_data_d  = rd_accept ? rd_word : rd1_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_valid_q <= 1'b0;
            rd1_data_q  <= '0;
        end else begin
            rd1_valid_q <= rd1_valid_d;
            rd1_data_q  <= rd1_data_d;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                  rd2_valid_q, rd2_valid_d;
            logic [DATA_WIDTH-1:0] rd2_data_q, rd2_data_d;

            always_comb begin
                rd2_valid_d = rd1_valid_q;
                rd2_data_d  = rd1_valid_q ? rd1_data_q : rd2_data_q;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd2_valid_q <= 1'b0;
                    rd2_data_q  <= '0;
                end else begin
                    rd2_valid_q <= rd2_valid_d;
                    rd2_data_q  <= rd2_data_d;
                end
            end

            assign rdata  = rd2_data_q;
            assign rvalid = rd2_valid_q;
        end else begin : g_lat1
            assign rdata  = rd1_data_q;
            assign rvalid = rd1_valid_q;
        end
    endgenerate

    assign init_done = init_done_q;

endmodule

// File: tb/tb_simple_dual_port_ram_pipe.sv
// Scoreboard bench: instance A uses latency 1 / old-data, instance B latency 2 / new-data.
module tb_simple_dual_port_ram_pipe;
    localparam int DW = 32;
    localparam int AW = 7;
    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wen = 1'b0;
    logic          ren = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [NB-1:0] wbe = '0;

    logic [DW-1:0] rdata_a, rdata_b;
    logic          rvalid_a, rvalid_b;
    logic          init_done_a, init_done_b;

    always #5 clk = ~clk;

    simple_dual_port_ram_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RD_LATENCY(1), .RDW_MODE(0)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a), .init_done(init_done_a)
    );

    simple_dual_port_ram_pipe #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .RD_LATENCY(2), .RDW_MODE(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b), .init_done(init_done_b)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rvalid_a === 1'b1) begin
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_spurious_rvalid: got rvalid=1 rdata=0x%08h expected no read (t=%0t)", rdata_a, $time);
            end else begin
                e = q_a.pop_front();
                $display("[TB] A read: rdata=0x%08h expected=0x%08h cycle=%0d due=%0d", rdata_a, e.data, cyc, e.due);
                check("a_rdata", rdata_a, e.data);
                check("a_latency", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rvalid_b === 1'b1) begin
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_spurious_rvalid: got rvalid=1 rdata=0x%08h expected no read (t=%0t)", rdata_b, $time);
            end else begin
                e = q_b.pop_front();
                $display("[TB] B read: rdata=0x%08h expected=0x%08h cycle=%0d due=%0d", rdata_b, e.data, cyc, e.due);
                check("b_rdata", rdata_b, e.data);
                check("b_latency", cyc, e.due);
            end
        end
    end

    // Called 1 time unit after a rising edge; the next edge accepts the inputs.
    task automatic op(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [NB-1:0] be, input logic r, input logic [AW-1:0] ra,
                      input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        wen   = w;
        waddr = wa;
        wdata = wd;
        wbe   = be;
        ren   = r;
        raddr = ra;
        if (r) begin
            q_a.push_back('{data: ea, due: cyc + 1});
            q_b.push_back('{data: eb, due: cyc + 2});
        end
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
    endtask

    task automatic wait_init(input string name, input int toggle_edges);
        int n_a = 0;
        int n_b = 0;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if ((n_a == 0) && init_done_a) n_a = n;
            if ((n_b == 0) && init_done_b) n_b = n;
            if (n <= toggle_edges) begin
                wen = n[0]; ren = ~n[0]; waddr = 7'd5; raddr = 7'd5; wdata = '1; wbe = '1;
            end else begin
                wen = 1'b0; ren = 1'b0;
            end
            if ((n_a != 0) && (n_b != 0)) break;
        end
        check({name, "_a"}, n_a, 128);
        check({name, "_b"}, n_b, 128);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata_a", rdata_a, 0);
        check("rst_rvalid_a", {31'd0, rvalid_a}, 0);
        check("rst_init_a", {31'd0, init_done_a}, 0);
        check("rst_rdata_b", rdata_b, 0);
        check("rst_rvalid_b", {31'd0, rvalid_b}, 0);
        check("rst_init_b", {31'd0, init_done_b}, 0);

        // Clear interrupted at count 60 with traffic on the user ports.
        rst_n = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            wen = n[0]; ren = ~n[0]; waddr = 7'd5; raddr = 7'd5; wdata = '1; wbe = '1;
        end
        rst_n = 1'b0;
        wen   = 1'b0;
        ren   = 1'b0;
        #1;
        check("midclear_init_a", {31'd0, init_done_a}, 0);
        check("midclear_init_b", {31'd0, init_done_b}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init("init_edges", 50);

        op(1'b0, 0, 0, 0, 1'b1, 7'd0,   32'h0, 32'h0);
        op(1'b0, 0, 0, 0, 1'b1, 7'd64,  32'h0, 32'h0);
        op(1'b0, 0, 0, 0, 1'b1, 7'd127, 32'h0, 32'h0);
        op(1'b0, 0, 0, 0, 1'b1, 7'd5,   32'h0, 32'h0);

        op(1'b1, 7'd5, 32'hDEADBEEF, 4'b1111, 1'b0, 0, 0, 0);
        op(1'b1, 7'd5, 32'h11223344, 4'b0101, 1'b0, 0, 0, 0);
        op(1'b0, 0, 0, 0, 1'b1, 7'd5, 32'hDE22BE44, 32'hDE22BE44);

        op(1'b1, 7'd1, 32'h0000000A, 4'b1111, 1'b0, 0, 0, 0);
        op(1'b1, 7'd2, 32'h0000000B, 4'b1111, 1'b0, 0, 0, 0);
        op(1'b1, 7'd3, 32'h0000000C, 4'b1111, 1'b0, 0, 0, 0);
        op(1'b0, 0, 0, 0, 1'b1, 7'd1, 32'hA, 32'hA);
        op(1'b0, 0, 0, 0, 1'b1, 7'd2, 32'hB, 32'hB);
        op(1'b0, 0, 0, 0, 1'b1, 7'd3, 32'hC, 32'hC);

        op(1'b1, 7'd9, 32'hFFFFFFFF, 4'b0011, 1'b1, 7'd9, 32'h00000000, 32'h0000FFFF);
        op(1'b0, 0, 0, 0, 1'b1, 7'd9, 32'h0000FFFF, 32'h0000FFFF);

        op(1'b1, 7'd5, 32'h00000000, 4'b0000, 1'b0, 0, 0, 0);
        op(1'b0, 0, 0, 0, 1'b1, 7'd5, 32'hDE22BE44, 32'hDE22BE44);

        op(1'b1, 7'd1, 32'h00000055, 4'b1111, 1'b1, 7'd2, 32'hB, 32'hB);
        op(1'b0, 0, 0, 0, 1'b1, 7'd1, 32'h55, 32'h55);
        repeat (3) @(posedge clk);
        #1;

        // Reset while instance B still holds the read in its second stage.
        ren   = 1'b1;
        raddr = 7'd3;
        q_a.push_back('{data: 32'hC, due: cyc + 1});
        @(posedge clk);
        #1;
        ren = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midread_rdata_a", rdata_a, 0);
        check("midread_rdata_b", rdata_b, 0);
        check("midread_rvalid_b", {31'd0, rvalid_b}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_init("reinit_edges", 0);
        op(1'b0, 0, 0, 0, 1'b1, 7'd5, 32'h0, 32'h0);
        repeat (4) @(posedge clk);
        #1;

        check("queue_empty_a", q_a.size(), 0);
        check("queue_empty_b", q_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/simple_dual_port_ram_pipe.md
SIMPLE_DUAL_PORT_RAM_PIPE -- requirements
Module: simple_dual_port_ram_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7, address width; depth DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8, lane width; NB = DATA_WIDTH/BYTE_WIDTH; DATA_WIDTH a multiple of BYTE_WIDTH.
REQ-004 SHALL have parameter RD_LATENCY, default 1, read latency in cycles; legal values 1 and 2.
REQ-005 SHALL have parameter RDW_MODE, default 0, same-address read-during-write result: 0 = old data, 1 = new data.
REQ-006 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port wen  input  1  write enable.
REQ-009 SHALL have port waddr  input  ADDR_WIDTH  write address.
REQ-010 SHALL have port wdata  input  DATA_WIDTH  write data.
REQ-011 SHALL have port wbe  input  NB  byte-lane enables; bit i covers wdata[i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-012 SHALL have port ren  input  1  read request.
REQ-013 SHALL have port raddr  input  ADDR_WIDTH  read address.
REQ-014 SHALL have port rdata  output  DATA_WIDTH  registered read data.
REQ-015 SHALL have port rvalid  output  1  one-cycle pulse marking rdata valid for one accepted read.
REQ-016 SHALL have port init_done  output  1  high once memory clear is complete.

Function
REQ-017 SHALL implement a 2-state FSM, CLEAR and READY; reset enters CLEAR with clear counter = 0.
REQ-018 In CLEAR, each rising edge SHALL write all-zero to mem[counter] and increment the counter.
REQ-019 The edge that clears address DEPTH-1 SHALL move the FSM to READY and set init_done = 1.
REQ-020 With default parameters, init_done SHALL rise on the 128th rising edge after rst_n deasserts.
REQ-021 In CLEAR, wen and ren SHALL be ignored: no user write, no read accepted, rvalid = 0.
REQ-022 In READY with wen = 1, each lane i with wbe[i] = 1 SHALL take wdata lane i at mem[waddr]; lanes with wbe[i] = 0 keep their value.
REQ-023 wen = 1 with wbe = 0 SHALL leave memory unchanged.
REQ-024 In READY, ren = 1 at edge N SHALL drive rdata with mem[raddr] and pulse rvalid at edge N+RD_LATENCY-1.
REQ-025 RD_LATENCY = 1 SHALL mean rdata/rvalid update at the accepting edge; RD_LATENCY = 2 SHALL add one pipeline register stage to both data and valid.
REQ-026 Reads SHALL be fully pipelined: one read accepted every cycle, results returned in request order, one rvalid pulse each.
REQ-027 When rvalid = 0, rdata SHALL hold its last value.
REQ-028 For wen & ren on the same address in the same cycle, RDW_MODE = 0 SHALL return the pre-write word.
REQ-029 For the same case, RDW_MODE = 1 SHALL return the merged word: enabled lanes from wdata, other lanes from the old word.
REQ-030 For wen & ren on different addresses, the read SHALL return the stored word, unaffected by the write.

Reset
REQ-031 rst_n = 0 SHALL immediately force rdata = 0, rvalid = 0, init_done = 0, pipeline valid bits = 0, FSM = CLEAR, counter = 0, regardless of clk.
REQ-032 Reset asserted mid-clear or mid-read SHALL discard in-flight reads (no rvalid) and restart the full clear from address 0 after release.
REQ-033 Memory contents SHALL be defined only by the clear sequence, with no reset term on the array itself.

Verification
REQ-034 Release reset, idle -> init_done = 0 for 127 edges and 1 on edge 128; reading addresses 0, 64 and 127 then returns 0x00000000.
REQ-035 After init: write 0xDEADBEEF to addr 5 with wbe = 4'b1111, then 0x11223344 to addr 5 with wbe = 4'b0101 -> read of addr 5 returns 0xDE22BE44.
REQ-036 RD_LATENCY = 2: reads of addr 1, 2, 3 on consecutive cycles (holding 0xA, 0xB, 0xC) -> rvalid high on three consecutive cycles starting 2 edges after the first request, rdata 0xA, 0xB, 0xC in order.
REQ-037 Addr 9 = 0x00000000; same cycle wen = 1, wdata = 0xFFFFFFFF, wbe = 4'b0011, ren = 1, raddr = 9 -> rdata 0x00000000 (RDW_MODE = 0) or 0x0000FFFF (RDW_MODE = 1); a following read returns 0x0000FFFF in both modes.
REQ-038 Pulse ren/wen during clear, and assert rst_n = 0 at clear count 60 -> no memory change, no rvalid; init_done rises exactly 128 edges after the second release.
REQ-039 Reset while a read is in flight with RD_LATENCY = 2 -> rvalid never pulses for that read; rdata = 0 immediately.
